// File: rtl/alu_arbiter.sv
// alu_arbiter: two valid/ready requesters time-share one external combinational ALU.
// Optional macro ALU_ARB_ROUND_ROBIN_EN selects round-robin tie-break; default is fixed priority (req0).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req0_* / req1_*           valid (in), ready (out), op1/op2 (in 32), alu_op (in 4)
//   alu_op1/alu_op2/alu_alu_op  operands and opcode driven to the shared ALU (registered)
//   alu_result/alu_zero       shared ALU outputs (combinational, sampled in EXEC)
//   rsp_valid/rsp_ready       response handshake
//   rsp_id/rsp_result/rsp_zero  registered response fields
module alu_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_op1,
   input  logic [31:0] req0_op2,
   input  logic [3:0]  req0_alu_op,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_op1,
   input  logic [31:0] req1_op2,
   input  logic [3:0]  req1_alu_op,
   output logic [31:0] alu_op1,
   output logic [31:0] alu_op2,
   output logic [3:0]  alu_alu_op,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_result,
   output logic        rsp_zero
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] op1_q, op2_q;
   logic [3:0]  aop_q;
   logic        id_q;
   logic        last_grant_q;
   logic        rsp_id_q;
   logic [31:0] rsp_result_q;
   logic        rsp_zero_q;
   logic        grant;
   logic        accept;

   // grant: 0 selects requester 0, 1 selects requester 1.
   // Only meaningful when at least one valid is high.
   always_comb begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      if (req0_valid && req1_valid) begin
         grant = ~last_grant_q;
      end else begin
         grant = ~req0_valid;
      end
`else
      // Fixed priority. last_grant_q only fills the don't-care
      // case where neither requester is valid.
      grant = ~req0_valid & (req1_valid | last_grant_q);
`endif
   end

   always_comb begin
      state_d    = state_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      accept     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if ((req0_valid || req1_valid) && !rst) begin
               accept     = 1'b1;
               req0_ready = ~grant;
               req1_ready = grant;
               state_d    = EXEC;
            end
         end
         EXEC: begin
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         op1_q        <= '0;
         op2_q        <= '0;
         aop_q        <= '0;
         id_q         <= 1'b0;
         last_grant_q <= 1'b1;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op1_q        <= grant ? req1_op1 : req0_op1;
            op2_q        <= grant ? req1_op2 : req0_op2;
            aop_q        <= grant ? req1_alu_op : req0_alu_op;
            id_q         <= grant;
            last_grant_q <= grant;
         end
         if (state_q == EXEC) begin
            rsp_result_q <= alu_result;
            rsp_zero_q   <= alu_zero;
            rsp_id_q     <= id_q;
         end
      end
   end

   assign alu_op1    = op1_q;
   assign alu_op2    = op2_q;
   assign alu_alu_op = aop_q;
   assign rsp_valid  = (state_q == RESP);
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural ALU.
// Expected responses are queued at acceptance and checked by a monitor.
module tb_alu_arbiter;

   localparam logic [3:0] ALUOP_ADD = 4'd0;
   localparam logic [3:0] ALUOP_SUB = 4'd1;
   localparam logic [3:0] ALUOP_AND = 4'd2;
   localparam logic [3:0] ALUOP_OR  = 4'd3;
   localparam logic [3:0] ALUOP_XOR = 4'd4;
   localparam logic [3:0] ALUOP_SLL = 4'd5;
   localparam logic [3:0] ALUOP_SRL = 4'd6;
   localparam logic [3:0] ALUOP_SRA = 4'd7;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_op1 = '0, req0_op2 = '0;
   logic [31:0] req1_op1 = '0, req1_op2 = '0;
   logic [3:0]  req0_alu_op = '0, req1_alu_op = '0;
   logic [31:0] alu_op1, alu_op2;
   logic [3:0]  alu_alu_op;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic        rsp_id;
   logic [31:0] rsp_result;
   logic        rsp_zero;

   typedef struct {
      logic        id;
      logic [31:0] res;
      logic        zero;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   fails  = 0;

   alu_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op1   (req0_op1),
      .req0_op2   (req0_op2),
      .req0_alu_op(req0_alu_op),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op1   (req1_op1),
      .req1_op2   (req1_op2),
      .req1_alu_op(req1_alu_op),
      .alu_op1    (alu_op1),
      .alu_op2    (alu_op2),
      .alu_alu_op (alu_alu_op),
      .alu_result (alu_result),
      .alu_zero   (alu_zero),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero)
   );

   always #5 clk = ~clk;

   // Shared combinational ALU seen by the arbiter.
   always_comb begin
      alu_result = '0;
      unique case (alu_alu_op)
         ALUOP_ADD: alu_result = alu_op1 + alu_op2;
         ALUOP_SUB: alu_result = alu_op1 - alu_op2;
         ALUOP_AND: alu_result = alu_op1 & alu_op2;
         ALUOP_OR:  alu_result = alu_op1 | alu_op2;
         ALUOP_XOR: alu_result = alu_op1 ^ alu_op2;
         ALUOP_SLL: alu_result = alu_op1 << alu_op2[4:0];
         ALUOP_SRL: alu_result = alu_op1 >> alu_op2[4:0];
         ALUOP_SRA: alu_result = $unsigned($signed(alu_op1) >>> alu_op2[4:0]);
         default:   alu_result = '0;
      endcase
      alu_zero = (alu_result == 32'd0);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] want);
      checks++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, want);
      end
   endtask

   // Monitor: every accepted response is compared to the queue head.
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
            chk("rsp_result", rsp_result, e.res);
            chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
         end
      end
   end

   task automatic issue(input logic id, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] op,
                        input logic [31:0] er, input logic ez,
                        input bit exp_rsp);
      int   n;
      logic rdy;
      exp_t e;
      n = 0;
      rdy = 1'b0;
      @(posedge clk); #1;
      if (id == 1'b0) begin
         req0_valid = 1'b1; req0_op1 = a;
         req0_op2 = b; req0_alu_op = op;
      end else begin
         req1_valid = 1'b1; req1_op1 = a;
         req1_op2 = b; req1_alu_op = op;
      end
      while (!rdy && n < 20) begin
         @(negedge clk);
         n++;
         rdy = id ? req1_ready : req0_ready;
      end
      chk("accept", {31'd0, rdy}, 32'd1);
      if (rdy && exp_rsp) begin
         e.id = id; e.res = er; e.zero = ez;
         q.push_back(e);
      end
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("drain", q.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit g [4];
      bit exp_g [4];
      int ng, n;
      exp_t e;
      logic [31:0] hold_res;

`ifdef ALU_ARB_ROUND_ROBIN_EN
      exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

      // Reset with both requesters pending.
      rst = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
         chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
         chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
         chk("rst_rsp_result", rsp_result, 32'd0);
         chk("rst_rsp_zero", {31'd0, rsp_zero}, 32'd0);
         chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
         chk("rst_alu_op1", alu_op1, 32'd0);
         chk("rst_alu_op2", alu_op2, 32'd0);
         chk("rst_alu_op", {28'd0, alu_alu_op}, 32'd0);
      end
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst = 1'b0;
      rsp_ready = 1'b1;

      // Single op with latency check.
      issue(1'b0, 32'd5, 32'd7, ALUOP_ADD, 32'd12, 1'b0, 1'b1);
      @(negedge clk);
      chk("lat_exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("lat_exec_alu_op1", alu_op1, 32'd5);
      @(negedge clk);
      chk("lat_resp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      drain();

      // Zero flag and id, then arithmetic shift.
      issue(1'b1, 32'd9, 32'd9, ALUOP_SUB, 32'd0, 1'b1, 1'b1);
      drain();
      issue(1'b1, 32'h8000_0000, 32'd4, ALUOP_SRA,
            32'hF800_0000, 1'b0, 1'b1);
      drain();

      // Contention: both requesters continuously valid.
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_op1 = 32'd1;
      req0_op2 = 32'd2; req0_alu_op = ALUOP_ADD;
      req1_valid = 1'b1; req1_op1 = 32'd10;
      req1_op2 = 32'd20; req1_alu_op = ALUOP_ADD;
      ng = 0;
      n = 0;
      while (ng < 4 && n < 60) begin
         @(negedge clk);
         n++;
         if (req0_ready && req1_ready) begin
            chk("both_ready", 32'd1, 32'd0);
         end
         if (req0_ready) begin
            g[ng] = 1'b0; ng++;
            e.id = 1'b0; e.res = 32'd3; e.zero = 1'b0;
            q.push_back(e);
         end else if (req1_ready) begin
            g[ng] = 1'b1; ng++;
            e.id = 1'b1; e.res = 32'd30; e.zero = 1'b0;
            q.push_back(e);
         end
      end
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk("grant_count", ng, 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("grant%0d", i), {31'd0, g[i]}, {31'd0, exp_g[i]});
      end
      drain();

      // Backpressure in RESP with another request pending.
      rsp_ready = 1'b0;
      issue(1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, ALUOP_AND,
            32'h0F00_0F00, 1'b0, 1'b1);
      req1_valid = 1'b1; req1_op1 = 32'd4;
      req1_op2 = 32'd4; req1_alu_op = ALUOP_ADD;
      @(negedge clk);
      @(negedge clk);
      hold_res = rsp_result;
      chk("bp_first_result", hold_res, 32'h0F00_0F00);
      repeat (5) begin
         chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_rsp_result", rsp_result, 32'h0F00_0F00);
         chk("bp_rsp_id", {31'd0, rsp_id}, 32'd0);
         chk("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
         chk("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
      chk("bp_next_accept", {31'd0, req1_ready}, 32'd1);
      e.id = 1'b1; e.res = 32'd8; e.zero = 1'b0;
      q.push_back(e);
      @(posedge clk); #1;
      req1_valid = 1'b0;
      drain();

      // Reset during EXEC discards the operation.
      issue(1'b0, 32'h0000_00F0, 32'h0000_000F, ALUOP_OR,
            32'h0000_00FF, 1'b0, 1'b0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         chk("rexec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      end
      chk("rexec_alu_op1", alu_op1, 32'd0);
      chk("rexec_rsp_result", rsp_result, 32'd0);

      // Normal operation after reset, including an undefined opcode.
      issue(1'b0, 32'd5, 32'd3, ALUOP_XOR, 32'd6, 1'b0, 1'b1);
      drain();
      issue(1'b1, 32'd5, 32'd3, 4'hF, 32'd0, 1'b1, 1'b1);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
